// File: rtl/prio_range_classifier_if.sv
`default_nettype none
// ============================================================================
//  Module   : prio_range_classifier_if
//  Purpose  : Handshake bundle for prio_range_classifier. It carries the
//             input stream (valid/ready/data) and the classified output stream
//             (valid/ready/class/data).
//  Modports : master - source/consumer side; drives in_valid, in_data and
//                      out_ready
//             slave  - classifier side; drives in_ready, out_valid, out_class
//                      and out_data
//  Revision : 1.0 - initial release
// ============================================================================
interface prio_range_classifier_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_class;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_class, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_class, out_data
  );
endinterface
`default_nettype wire

// File: rtl/prio_range_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : prio_range_classifier
//  Purpose  : Maps each accepted input word to a class by magnitude band
//             (first-match priority, last class is the catch-all), presents
//             class and data on a registered valid/ready stage and keeps a
//             saturating hit counter per class.
//  Ports    : clk      - clock, rising edge
//             rstn     - asynchronous active-low reset
//             bus      - slave modport: in_valid/in_ready/in_data,
//                        out_valid/out_ready/out_class/out_data
//             clr      - synchronous clear of all hit counters (beats accept)
//             cnt_sel  - counter read select
//             cnt_val  - hit count of class cnt_sel (0 if out of range)
//             err_x    - sticky unknown-input flag
//  Config   : PRC_XCHECK_EN - when defined, accepted words with X/Z bits set
//             err_x, are forced to the catch-all class and reported with
//             $error. When undefined, err_x is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module prio_range_classifier #(
  parameter int WIDTH     = 8,
  parameter int BASE_BITS = 1,
  parameter int NCLASS    = 4,
  parameter int CNT_W     = 16,
  localparam int CW       = (NCLASS > 1) ? $clog2(NCLASS) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  prio_range_classifier_if.slave bus,
  input  logic                  clr,
  input  logic [CW-1:0]         cnt_sel,
  output logic [CNT_W-1:0]      cnt_val,
  output logic                  err_x
);

  logic             w_accept;
  logic [CW-1:0]    w_class_raw;
  logic [CW-1:0]    w_class;
  logic             r_out_valid;
  logic [CW-1:0]    r_out_class;
  logic [WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0] r_cnt [NCLASS];

  assign bus.in_ready  = !r_out_valid || bus.out_ready;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_class = r_out_class;
  assign bus.out_data  = r_out_data;

  // Band test "data < 2**T" is done as "no bits set at or above T"; a shift
  // of T >= WIDTH yields zero, so wide thresholds need no wider compare.
  // Walking from the highest band down lets the lowest match win.
  always_comb begin
    w_class_raw = CW'(NCLASS - 1);
    for (int k = NCLASS - 2; k >= 0; k--) begin
      if ((bus.in_data >> (BASE_BITS + k)) == '0) begin
        w_class_raw = CW'(k);
      end
    end
  end

`ifdef PRC_XCHECK_EN
  logic w_xbad;
  logic r_err_x;

  assign w_xbad  = $isunknown(bus.in_data);
  assign w_class = w_xbad ? CW'(NCLASS - 1) : w_class_raw;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_x <= 1'b0;
    end else if (w_accept && w_xbad) begin
      r_err_x <= 1'b1;
      $error("prio_range_classifier: unknown input at %0t, data=%b", $time, bus.in_data);
    end
  end

  assign err_x = r_err_x;
`else
  assign w_class = w_class_raw;
  assign err_x   = 1'b0;
`endif

  // Output register: load on accept, drain when consumer takes it, else hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_class <= w_class;
      r_out_data  <= bus.in_data;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Hit counters: clear has priority over counting the same-cycle word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCLASS; i++) r_cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCLASS; i++) r_cnt[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NCLASS; i++) begin
        if (w_class == CW'(i) && r_cnt[i] != '1) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Select by comparison so an out-of-range cnt_sel never indexes the array
  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < NCLASS; i++) begin
      if (cnt_sel == CW'(i)) cnt_val = r_cnt[i];
    end
  end

endmodule
`default_nettype wire
